dadda_mult_pipe: RTL

Parametrised, pipelined successor to the combinational 8×8 Dadda reduction block. It multiplies two WIDTH-bit operands, unsigned or two's-complement signed, selected per transaction. Partial products are reduced to two rows by a generated Dadda tree, and those rows are summed by a registered carry-propagate adder. It sits between the operand sequencer and the result FIFO, with a valid/ready handshake on both sides, and replaces the fixed-width block wherever a registered, back-pressurable multiplier is needed.

---
 rtl/dadda_mult_pipe.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dadda_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dadda_mult_pipe
// Purpose  : Three-stage pipelined WIDTH x WIDTH multiplier. It handles
//            unsigned operands, or two's-complement signed operands using
//            Baugh-Wooley, as selected per transaction. A generated Dadda
//            tree reduces the partial products to two rows, and a registered
//            carry-propagate adder sums those rows. Both sides use a
//            valid/ready handshake, and one global stall enable holds every
//            stage.
// Ports    : clk, rst (sync, active-high)
//            in_valid / in_ready, a, b, sgn, in_tag  : operand side
//            out_valid / out_ready, p, out_tag       : result side
// Revision : 1.0 - initial parametrised pipelined release
// ============================================================================
module dadda_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW   = 2 * WIDTH;
  // The tallest column is column WIDTH-1 (WIDTH products), or column WIDTH
  // (WIDTH-1 products plus the signed-mode constant).
  localparam int MAXH = WIDTH;

  // Dadda height target k: d0=2, d(k+1)=floor(1.5*dk)
  function automatic int dk(input int k);
    int d;
    d = 2;
    for (int i = 0; i < k; i++) d = (d * 3) / 2;
    return d;
  endfunction

  // Number of targets below the initial maximum height
  function automatic int num_stages(input int w);
    int d;
    int n;
    d = 2;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (d < w) begin
        n++;
        d = (d * 3) / 2;
      end
    end
    return n;
  endfunction

  localparam int NST = num_stages(WIDTH);

  logic               adv;
  logic               v1, v2, v3;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_q;
  logic [TAG_W-1:0]   tag1, tag2;
  logic [PW-1:0]      row0, row1;
  logic [PW-1:0]      row0_n, row1_n;

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  // Partial-product matrix followed by Dadda reduction down to two rows.
  // Column heights depend only on WIDTH, so every loop unrolls to a fixed
  // network of half and full adders.
  always_comb begin : g_reduce
    logic [MAXH-1:0] cur [PW];
    logic [MAXH-1:0] nxt [PW];
    int              hc  [PW];
    int              hn  [PW];
    int              idx;
    int              e;
    int              d;
    logic            x, y, z, bit_v;

    cur    = '{default: '0};
    nxt    = '{default: '0};
    hc     = '{default: 0};
    hn     = '{default: 0};
    idx    = 0;
    e      = 0;
    d      = 0;
    x      = 1'b0;
    y      = 1'b0;
    z      = 1'b0;
    bit_v  = 1'b0;
    row0_n = '0;
    row1_n = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        bit_v = a_q[i] & b_q[j];
        // Baugh-Wooley: invert the terms where exactly one index is the MSB
        if (sgn_q && ((i == WIDTH-1) != (j == WIDTH-1))) bit_v = ~bit_v;
        cur[i+j][hc[i+j]] = bit_v;
        hc[i+j]++;
      end
    end
    // Baugh-Wooley correction constants, present only in signed mode
    cur[WIDTH][hc[WIDTH]] = sgn_q;
    hc[WIDTH]++;
    cur[PW-1][hc[PW-1]] = sgn_q;
    hc[PW-1]++;

    for (int s = NST-1; s >= 0; s--) begin
      d   = dk(s);
      nxt = '{default: '0};
      hn  = '{default: 0};
      for (int c = 0; c < PW; c++) begin
        idx = 0;
        // hn[c] already holds the carries from column c-1 for this stage
        for (int r = 0; r < MAXH; r++) begin
          e = hc[c] - idx + hn[c];
          if (e > d) begin
            x = cur[c][idx];
            y = cur[c][idx+1];
            if (e == d + 1) begin
              z   = 1'b0;
              idx = idx + 2;
            end else begin
              z   = cur[c][idx+2];
              idx = idx + 3;
            end
            nxt[c][hn[c]] = x ^ y ^ z;
            hn[c]++;
            // Carry out of the top column is beyond 2*WIDTH and is dropped
            if (c + 1 < PW) begin
              nxt[c+1][hn[c+1]] = (x & y) | (x & z) | (y & z);
              hn[c+1]++;
            end
          end
        end
        for (int r = 0; r < MAXH; r++) begin
          if (r >= idx && r < hc[c]) begin
            nxt[c][hn[c]] = cur[c][r];
            hn[c]++;
          end
        end
      end
      cur = nxt;
      hc  = hn;
    end

    for (int c = 0; c < PW; c++) begin
      row0_n[c] = (hc[c] > 0) ? cur[c][0] : 1'b0;
      row1_n[c] = (hc[c] > 1) ? cur[c][1] : 1'b0;
    end
  end

  // All stages advance together. When stalled, every register holds,
  // including the data registers of empty stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      tag1    <= '0;
      row0    <= '0;
      row1    <= '0;
      tag2    <= '0;
      p       <= '0;
      out_tag <= '0;
    end else if (adv) begin
      v1      <= in_valid;
      a_q     <= a;
      b_q     <= b;
      sgn_q   <= sgn;
      tag1    <= in_tag;
      v2      <= v1;
      row0    <= row0_n;
      row1    <= row1_n;
      tag2    <= tag1;
      v3      <= v2;
      p       <= row0 + row1;
      out_tag <= tag2;
    end
  end

endmodule
`default_nettype wire
